music_sequencer: RTL and testbench

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

---
 rtl/music_sequencer_pkg.sv | 38 +++
 rtl/note_freq_lut.sv | 24 ++
 rtl/music_sequencer.sv | 142 ++++++++++++++
 tb/tb_music_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_sequencer_pkg.sv
// Shared definitions for the music sequencer: note base frequencies,
// the silence tone, the sequencer state set and the tempo_sel encoding.
package music_sequencer_pkg;

    localparam int TONE_W = 32;

    // A tone this high is inaudible, so it doubles as "no note playing".
    localparam logic [TONE_W-1:0] SILENCE_HZ = 32'd20000;

    // Base (lowest octave) frequencies for note indices 1..7.
    localparam logic [TONE_W-1:0] FREQ_N1 = 32'd277;
    localparam logic [TONE_W-1:0] FREQ_N2 = 32'd294;
    localparam logic [TONE_W-1:0] FREQ_N3 = 32'd330;
    localparam logic [TONE_W-1:0] FREQ_N4 = 32'd370;
    localparam logic [TONE_W-1:0] FREQ_N5 = 32'd392;
    localparam logic [TONE_W-1:0] FREQ_N6 = 32'd440;
    localparam logic [TONE_W-1:0] FREQ_N7 = 32'd494;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        TEMPO_X1   = 2'd0,
        TEMPO_X2   = 2'd1,
        TEMPO_X4   = 2'd2,
        TEMPO_HALF = 2'd3
    } tempo_e;

    // Indices outside 1..7 carry no note and must never be octave-shifted.
    function automatic logic isSilentIndex(input logic [3:0] index);
        return (index == 4'd0) || (index > 4'd7);
    endfunction

endpackage

// File: rtl/note_freq_lut.sv
// Combinational lookup from a 4-bit note index to its base frequency in Hz.
module note_freq_lut
    import music_sequencer_pkg::*;
(
    input  logic [3:0]        i_index,
    output logic [TONE_W-1:0] o_freq
);

    // Unused indices fall through to silence.
    always_comb begin
        o_freq = SILENCE_HZ;
        case (i_index)
            4'd1:    o_freq = FREQ_N1;
            4'd2:    o_freq = FREQ_N2;
            4'd3:    o_freq = FREQ_N3;
            4'd4:    o_freq = FREQ_N4;
            4'd5:    o_freq = FREQ_N5;
            4'd6:    o_freq = FREQ_N6;
            4'd7:    o_freq = FREQ_N7;
            default: o_freq = SILENCE_HZ;
        endcase
    end

endmodule

// File: rtl/music_sequencer.sv
// Beat sequencer: steps a song ROM address at a selectable tempo and turns
// each channel's note code into a registered tone frequency.
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int BEAT_W        = 8,
    parameter int SONG_LEN      = 256,
    parameter int CLK_HZ        = 100_000_000,
    parameter int BEATS_PER_SEC = 8,
    parameter int NUM_CH        = 2
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       play,
    input  logic                       stop,
    input  logic                       loop,
    input  logic [1:0]                 tempo_sel,
    input  logic [1:0]                 transpose,
    input  logic [6*NUM_CH-1:0]        note_code,
    output logic [BEAT_W-1:0]          beat_num,
    output logic [TONE_W*NUM_CH-1:0]   tone,
    output logic                       playing,
    output logic                       done
);

    localparam int BASE_PERIOD = CLK_HZ / BEATS_PER_SEC;
    localparam int PER_X1      = (BASE_PERIOD < 1) ? 1 : BASE_PERIOD;
    localparam int PER_X2      = (PER_X1 / 2 < 1) ? 1 : PER_X1 / 2;
    localparam int PER_X4      = (PER_X1 / 4 < 1) ? 1 : PER_X1 / 4;
    localparam int PER_HALF    = 2 * PER_X1;
    localparam int DIV_W       = $clog2(PER_HALF + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN - 1);

    seq_state_e          r_state;
    seq_state_e          w_nextState;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    w_periodM1;
    logic [BEAT_W-1:0]   r_beatNum;
    logic                r_done;
    logic                w_tick;
    logic                w_lastBeat;
    logic                w_doneNext;

    // Terminal divider value for the selected tempo.
    always_comb begin
        w_periodM1 = DIV_W'(PER_X1 - 1);
        case (tempo_e'(tempo_sel))
            TEMPO_X1:   w_periodM1 = DIV_W'(PER_X1 - 1);
            TEMPO_X2:   w_periodM1 = DIV_W'(PER_X2 - 1);
            TEMPO_X4:   w_periodM1 = DIV_W'(PER_X4 - 1);
            TEMPO_HALF: w_periodM1 = DIV_W'(PER_HALF - 1);
            default:    w_periodM1 = DIV_W'(PER_X1 - 1);
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Next state and tick decode; >= lets a tempo speed-up mid-count tick at once.
    always_comb begin
        w_nextState = r_state;
        w_lastBeat  = (r_beatNum == LAST_BEAT);
        w_tick      = (r_state == ST_PLAY) && play && !stop && (r_div >= w_periodM1);
        w_doneNext  = w_tick && w_lastBeat && !loop;
        if (stop) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (play) w_nextState = ST_PLAY;
                ST_PLAY: begin
                    if (!play)           w_nextState = ST_PAUSE;
                    else if (w_doneNext) w_nextState = ST_DONE;
                end
                ST_PAUSE: if (play)  w_nextState = ST_PLAY;
                ST_DONE:  if (!play) w_nextState = ST_IDLE;
                default:  w_nextState = ST_IDLE;
            endcase
        end
    end

    // Beat address, tempo divider and end-of-song pulse; pause simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beatNum <= '0;
            r_div     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_doneNext;
            if (w_nextState == ST_IDLE) begin
                r_beatNum <= '0;
                r_div     <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                if (!w_lastBeat)  r_beatNum <= r_beatNum + BEAT_W'(1);
                else if (loop)    r_beatNum <= '0;
            end else if ((r_state == ST_PLAY) && (w_nextState == ST_PLAY)) begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
            logic [3:0]        w_index;
            logic [1:0]        w_octave;
            logic [2:0]        w_shift;
            logic [TONE_W-1:0] w_base;
            logic [TONE_W-1:0] w_tone;
            logic [TONE_W-1:0] r_tone;

            assign w_index  = note_code[6*ch +: 4];
            assign w_octave = note_code[6*ch+4 +: 2];
            assign w_shift  = {1'b0, w_octave} + {1'b0, transpose};

            note_freq_lut u_lut (
                .i_index (w_index),
                .o_freq  (w_base)
            );

            assign w_tone = isSilentIndex(w_index) ? SILENCE_HZ : (w_base << w_shift);

            // Keyed off the next state so leaving PLAY goes silent immediately.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                       r_tone <= SILENCE_HZ;
                else if (w_nextState == ST_PLAY)  r_tone <= w_tone;
                else                              r_tone <= SILENCE_HZ;
            end

            assign tone[TONE_W*ch +: TONE_W] = r_tone;
        end
    endgenerate

    assign beat_num = r_beatNum;
    assign playing  = (r_state == ST_PLAY);
    assign done     = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: decode table, directed sequences
// for sequencing/looping/pause/stop/reset, then randomized run vs a model.
module tb_music_sequencer;

    localparam int NCH     = 2;
    localparam int SLEN    = 4;
    localparam int PBASE   = 10;
    localparam int SILENCE = 20000;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic              clk;
    logic              rst_n;
    logic              play;
    logic              stop;
    logic              loop;
    logic [1:0]        tempoSel;
    logic [1:0]        transpose;
    logic [6*NCH-1:0]  noteCode;
    logic [1:0]        beatNum;
    logic [32*NCH-1:0] tone;
    logic              playing;
    logic              done;

    logic [5:0] romCode [NCH][SLEN];

    int compared   = 0;
    int mismatched = 0;
    int doneTally  = 0;

    int mState, mBeat, mDiv, mDone;
    int mTone [NCH];

    typedef struct {
        logic [5:0] codeL;
        logic [5:0] codeR;
        logic [1:0] trans;
        int         expL;
        int         expR;
    } decodeVec_t;

    decodeVec_t vecs [6];

    music_sequencer #(
        .BEAT_W        (2),
        .SONG_LEN      (SLEN),
        .CLK_HZ        (80),
        .BEATS_PER_SEC (8),
        .NUM_CH        (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .stop      (stop),
        .loop      (loop),
        .tempo_sel (tempoSel),
        .transpose (transpose),
        .note_code (noteCode),
        .beat_num  (beatNum),
        .tone      (tone),
        .playing   (playing),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Song ROM: combinational read at the DUT's beat address.
    always_comb begin
        noteCode = '0;
        for (int c = 0; c < NCH; c++) noteCode[6*c +: 6] = romCode[c][beatNum];
    end

    function automatic int periodOf(input logic [1:0] t);
        case (t)
            2'd0:    return PBASE;
            2'd1:    return PBASE / 2;
            2'd2:    return PBASE / 4;
            default: return PBASE * 2;
        endcase
    endfunction

    function automatic int decodeHz(input logic [5:0] code, input logic [1:0] tr);
        int baseHz [8];
        int idx;
        baseHz = '{SILENCE, 277, 294, 330, 370, 392, 440, 494};
        idx = int'(code[3:0]);
        if (idx == 0 || idx > 7) return SILENCE;
        return baseHz[idx] * (1 << (int'(code[5:4]) + int'(tr)));
    endfunction

    task automatic modelReset();
        mState = M_IDLE;
        mBeat  = 0;
        mDiv   = 0;
        mDone  = 0;
        for (int c = 0; c < NCH; c++) mTone[c] = SILENCE;
    endtask

    // One clock of the song player, phrased as the rules of play/pause/stop.
    task automatic modelStep();
        int  per;
        int  oldBeat;
        bit  tk;
        per     = periodOf(tempoSel);
        oldBeat = mBeat;
        tk      = (mState == M_PLAY) && play && !stop && (mDiv >= per - 1);
        mDone   = (tk && oldBeat == SLEN - 1 && !loop) ? 1 : 0;
        if (stop) begin
            mState = M_IDLE; mBeat = 0; mDiv = 0;
        end else if (mState == M_IDLE) begin
            mBeat = 0; mDiv = 0;
            if (play) mState = M_PLAY;
        end else if (mState == M_PLAY) begin
            if (!play) mState = M_PAUSE;
            else if (tk) begin
                mDiv = 0;
                if (oldBeat < SLEN - 1) mBeat = oldBeat + 1;
                else if (loop)          mBeat = 0;
                else                    mState = M_DONE;
            end else mDiv = mDiv + 1;
        end else if (mState == M_PAUSE) begin
            if (play) mState = M_PLAY;
        end else begin
            if (!play) begin mState = M_IDLE; mBeat = 0; mDiv = 0; end
        end
        for (int c = 0; c < NCH; c++)
            mTone[c] = (mState == M_PLAY) ? decodeHz(romCode[c][oldBeat], transpose) : SILENCE;
    endtask

    task automatic checkOutput(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare everything.
    task automatic applyStimulus(input bit pl, input bit st, input bit lp,
                                 input logic [1:0] tp, input logic [1:0] tr);
        play = pl; stop = st; loop = lp; tempoSel = tp; transpose = tr;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        stop = 1'b0;
        if (done) doneTally++;
        checkOutput("beat_num", longint'(beatNum), longint'(mBeat));
        checkOutput("tone_ch0", longint'(tone[31:0]), longint'(mTone[0]));
        checkOutput("tone_ch1", longint'(tone[63:32]), longint'(mTone[1]));
        checkOutput("playing", longint'(playing), longint'(mState == M_PLAY));
        checkOutput("done", longint'(done), longint'(mDone));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic resetDut();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_beat", longint'(beatNum), 0);
        checkOutput("rst_tone0", longint'(tone[31:0]), SILENCE);
        checkOutput("rst_tone1", longint'(tone[63:32]), SILENCE);
        checkOutput("rst_playing", longint'(playing), 0);
        checkOutput("rst_done", longint'(done), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runUntilBeat(input int target, input int maxCycles, input bit pl,
                                input bit lp, input logic [1:0] tp, output int n);
        n = 0;
        do begin
            applyStimulus(pl, 1'b0, lp, tp, 2'd0);
            n++;
        end while (int'(beatNum) != target && n < maxCycles);
    endtask

    task automatic loadFixedRom();
        for (int b = 0; b < SLEN; b++) begin
            romCode[0][b] = {2'd1, 4'(b + 1)};
            romCode[1][b] = {2'd0, 4'd6};
        end
    endtask

    initial begin
        int n, d0, silentCycles, playCycles;
        bit rPlay, rLoop;
        logic [1:0] rTempo, rTrans;

        vecs[0] = '{6'h12, 6'h09, 2'd1, 1176,  SILENCE};
        vecs[1] = '{6'h01, 6'h37, 2'd0, 277,   3952};
        vecs[2] = '{6'h37, 6'h30, 2'd3, 31616, SILENCE};
        vecs[3] = '{6'h24, 6'h0F, 2'd2, 5920,  SILENCE};
        vecs[4] = '{6'h06, 6'h15, 2'd3, 3520,  6272};
        vecs[5] = '{6'h23, 6'h11, 2'd0, 1320,  554};

        rst_n = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0;
        tempoSel = 2'd0; transpose = 2'd0;
        loadFixedRom();
        modelReset();
        @(negedge clk);
        resetDut();

        $display("[TB] sequencing at x1");
        runUntilBeat(1, 30, 1'b1, 1'b0, 2'd0, n);
        checkOutput("seq_first_beat_cycles", n, 11);
        runUntilBeat(2, 30, 1'b1, 1'b0, 2'd0, n);
        checkOutput("seq_beat_period", n, 10);
        runUntilBeat(3, 30, 1'b1, 1'b0, 2'd0, n);
        checkOutput("seq_beat3_period", n, 10);
        d0 = doneTally;
        repeat (15) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        checkOutput("seq_done_pulses", doneTally - d0, 1);
        checkOutput("seq_hold_last", longint'(beatNum), 3);
        checkOutput("seq_not_playing", longint'(playing), 0);

        $display("[TB] looping at x4");
        @(negedge clk);
        resetDut();
        d0 = doneTally;
        runUntilBeat(3, 40, 1'b1, 1'b1, 2'd2, n);
        runUntilBeat(0, 10, 1'b1, 1'b1, 2'd2, n);
        checkOutput("loop_wrap_cycles", n, 2);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 2'd0);
        checkOutput("loop_no_done", doneTally - d0, 0);

        $display("[TB] pause mid-beat");
        resetDut();
        runUntilBeat(1, 30, 1'b1, 1'b0, 2'd0, n);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        silentCycles = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
            if (int'(tone[31:0]) == SILENCE && int'(tone[63:32]) == SILENCE) silentCycles++;
        end
        checkOutput("pause_silent_cycles", silentCycles, 20);
        playCycles = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
            if (beatNum == 2'd2) break;
            if (playing) playCycles++;
        end
        checkOutput("pause_resume_cycles", playCycles, 6);
        checkOutput("pause_resume_beat", longint'(beatNum), 2);

        $display("[TB] stop on a tick cycle");
        resetDut();
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
            n++;
        end while (!(mState == M_PLAY && mBeat >= 1 && mDiv == PBASE - 1) && n < 40);
        checkOutput("stop_reached_tick", longint'(n < 40), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
        checkOutput("stop_beat", longint'(beatNum), 0);
        checkOutput("stop_tone0", longint'(tone[31:0]), SILENCE);
        checkOutput("stop_playing", longint'(playing), 0);

        $display("[TB] decode table");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 2'd0);
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < SLEN; b++) begin
                romCode[0][b] = vecs[i].codeL;
                romCode[1][b] = vecs[i].codeR;
            end
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, vecs[i].trans);
            checkOutput("table_tone_l", longint'(tone[31:0]), longint'(vecs[i].expL));
            checkOutput("table_tone_r", longint'(tone[63:32]), longint'(vecs[i].expR));
        end

        $display("[TB] randomized run");
        resetDut();
        rPlay = 1'b1; rLoop = 1'b0; rTempo = 2'd2; rTrans = 2'd0;
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < SLEN; b++) romCode[c][b] = 6'($urandom_range(0, 63));
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 6)  rPlay  = ~rPlay;
            if ($urandom_range(0, 99) < 3)  rLoop  = ~rLoop;
            if ($urandom_range(0, 99) < 5)  rTempo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 5)  rTrans = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2)
                romCode[$urandom_range(0, NCH - 1)][$urandom_range(0, SLEN - 1)] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 999) < 3) resetDut();
            applyStimulus(rPlay, $urandom_range(0, 99) < 2, rLoop, rTempo, rTrans);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
